// File: rtl/program_memory_loader_if.sv
// Byte-stream program load channel: the source drives bytes, and the loader drives loadReady.
interface program_memory_loader_if;
    logic       loadStart;
    logic       loadValid;
    logic [7:0] loadByte;
    logic       loadLast;
    logic       loadReady;

    modport master (output loadStart, loadValid, loadByte, loadLast, input loadReady);
    modport slave  (input loadStart, loadValid, loadByte, loadLast, output loadReady);
endinterface

// File: rtl/program_memory_loader.sv
// Instruction memory plus byte-stream loader. The CPU is held in reset while loading. A fetch returns its word 1 cycle later.
// loadReady is high only in LOAD. Define PMEM_CHECKSUM_EN to add the loadChecksum output.
module program_memory_loader #(
    parameter  int PC_WIDTH          = 8,
    parameter  int INSTRUCTION_WIDTH = 16,
    localparam int BYTES_PER_WORD    = INSTRUCTION_WIDTH / 8
) (
    input  logic                         clock,
    input  logic                         isReset,
    input  logic [PC_WIDTH-1:0]          pc,
    output logic [INSTRUCTION_WIDTH-1:0] instruction,
    output logic                         cpuReset,
    program_memory_loader_if.slave       ld,
    output logic [PC_WIDTH:0]            loadCount,
    output logic                         loadOverflow,
    output logic                         busy
`ifdef PMEM_CHECKSUM_EN
    ,
    output logic [7:0]                   loadChecksum
`endif
);
    localparam int DEPTH = 2 ** PC_WIDTH;
    localparam int IW    = INSTRUCTION_WIDTH;
    localparam int IDX_W = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;

    typedef enum logic [1:0] {RUN, LOAD, FLUSH, RELEASE} state_t;

    state_t             state_q, state_d;
    logic [IW-1:0]      asm_q, asm_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [PC_WIDTH:0]  count_q, count_d;
    logic               ovf_q, ovf_d;
    logic               cpu_reset_q, cpu_reset_d;
    logic [IW-1:0]      instr_q, instr_d;
`ifdef PMEM_CHECKSUM_EN
    logic [7:0]         cks_q, cks_d;
`endif

    logic [IW-1:0]       mem [DEPTH];
    logic                mem_we;
    logic [PC_WIDTH-1:0] mem_waddr;
    logic [IW-1:0]       mem_wdata;

    logic          byte_acc;
    logic          word_done;
    logic          mem_full;
    logic [IW-1:0] word_full;
    logic [IW-1:0] word_flush;

    assign byte_acc   = (state_q == LOAD) && ld.loadValid;
    assign word_done  = byte_acc && (idx_q == IDX_W'(BYTES_PER_WORD - 1));
    // The word count is also the write address. The count saturates at DEPTH, so its MSB marks a full memory.
    assign mem_full   = count_q[PC_WIDTH];
    assign word_full  = (asm_q << 8) | IW'(ld.loadByte);
    assign word_flush = asm_q << (8 * (BYTES_PER_WORD - int'(idx_q)));

    always_comb begin
        state_d   = state_q;
        asm_d     = asm_q;
        idx_d     = idx_q;
        count_d   = count_q;
        ovf_d     = ovf_q;
        mem_we    = 1'b0;
        mem_waddr = count_q[PC_WIDTH-1:0];
        mem_wdata = word_full;
`ifdef PMEM_CHECKSUM_EN
        cks_d     = cks_q;
`endif
        case (state_q)
            RUN: begin
                if (ld.loadStart) begin
                    state_d = LOAD;
                    asm_d   = '0;
                    idx_d   = '0;
                    count_d = '0;
                    ovf_d   = 1'b0;
`ifdef PMEM_CHECKSUM_EN
                    cks_d   = '0;
`endif
                end
            end
            LOAD: begin
                if (ld.loadStart) begin
                    asm_d   = '0;
                    idx_d   = '0;
                    count_d = '0;
                    ovf_d   = 1'b0;
`ifdef PMEM_CHECKSUM_EN
                    cks_d   = '0;
`endif
                end else if (byte_acc) begin
`ifdef PMEM_CHECKSUM_EN
                    cks_d = cks_q + ld.loadByte;
`endif
                    if (word_done) begin
                        asm_d = '0;
                        idx_d = '0;
                        if (mem_full) begin
                            ovf_d = 1'b1;
                        end else begin
                            mem_we  = 1'b1;
                            count_d = count_q + 1'b1;
                        end
                        if (ld.loadLast) state_d = RELEASE;
                    end else begin
                        asm_d = word_full;
                        idx_d = idx_q + 1'b1;
                        if (ld.loadLast) state_d = FLUSH;
                    end
                end
            end
            FLUSH: begin
                mem_wdata = word_flush;
                asm_d     = '0;
                idx_d     = '0;
                if (mem_full) begin
                    ovf_d = 1'b1;
                end else begin
                    mem_we  = 1'b1;
                    count_d = count_q + 1'b1;
                end
                state_d = RELEASE;
            end
            RELEASE: state_d = RUN;
            default: state_d = RELEASE;
        endcase
        if (isReset) mem_we = 1'b0;
        cpu_reset_d = (state_d != RUN);
        instr_d     = (state_q == RUN) ? mem[pc] : '0;
    end

    always_ff @(posedge clock) begin
        if (isReset) begin
            state_q     <= RELEASE;
            asm_q       <= '0;
            idx_q       <= '0;
            count_q     <= '0;
            ovf_q       <= 1'b0;
            cpu_reset_q <= 1'b1;
            instr_q     <= '0;
`ifdef PMEM_CHECKSUM_EN
            cks_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            asm_q       <= asm_d;
            idx_q       <= idx_d;
            count_q     <= count_d;
            ovf_q       <= ovf_d;
            cpu_reset_q <= cpu_reset_d;
            instr_q     <= instr_d;
`ifdef PMEM_CHECKSUM_EN
            cks_q       <= cks_d;
`endif
        end
    end

    // Program words are deliberately not reset, so that they survive a CPU reset.
    always_ff @(posedge clock) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
    end

    assign instruction  = instr_q;
    assign cpuReset     = cpu_reset_q;
    assign loadCount    = count_q;
    assign loadOverflow = ovf_q;
    assign busy         = (state_q == LOAD) || (state_q == FLUSH);
    assign ld.loadReady = (state_q == LOAD);
`ifdef PMEM_CHECKSUM_EN
    assign loadChecksum = cks_q;
`endif
endmodule

// File: doc/program_memory_loader.md
Name: program_memory_loader

Overview:
- Instruction-side responder for the CPU core: answers each fetch on `pc` with the addressed `instruction` word.
- Drives the CPU's `isReset` input (via `cpuReset`).
- Contains a byte-stream program loader: holds the CPU in reset, assembles bytes into instruction words, writes them into program memory, then releases the CPU.
- Sits beside `CPU` in the top level, replacing a hard-wired program.

Parameters:
- PC_WIDTH, 8, fetch address width; memory depth = 2**PC_WIDTH words.
- INSTRUCTION_WIDTH, 16, instruction word width; must be a multiple of 8.
- BYTES_PER_WORD, INSTRUCTION_WIDTH/8, derived, not to be overridden.

Ports:
- clock  in  1  system clock, all logic on rising edge.
- isReset  in  1  synchronous active-high reset.
- pc  in  PC_WIDTH  fetch address from CPU.
- instruction  out  INSTRUCTION_WIDTH  fetched word, to CPU.
- cpuReset  out  1  drives CPU `isReset`.
- loadStart  in  1  single-cycle pulse: begin program load.
- loadValid  in  1  loadByte valid.
- loadByte  in  8  program byte, MSB-first within a word.
- loadLast  in  1  qualifies final byte of the program.
- loadReady  out  1  loader accepts a byte this cycle.
- loadCount  out  PC_WIDTH+1  words written in current/last load.
- loadOverflow  out  1  sticky: program exceeded memory depth.
- busy  out  1  high in LOAD or FLUSH.

Behaviour:
- Interface: one clock, `clock`; reset `isReset` is synchronous and active-high.
- States: RUN, LOAD, FLUSH, RELEASE.
- Reset: state=RELEASE, `cpuReset`=1, `instruction`=0, `loadCount`=0, `loadOverflow`=0, byte index=0, write address=0.
- Program memory contents are NOT reset; words survive `isReset`.
- `cpuReset` is registered: 1 in every state except RUN.
- `busy` = state is LOAD or FLUSH.
- `loadReady` = state is LOAD (combinational from state).
- Fetch: in RUN, `instruction` <= mem[pc] (1-cycle latency). In any other state, `instruction` <= 0 (NOP).
- RUN:
  - `loadStart` -> LOAD; clears write address, byte index, `loadCount`, `loadOverflow`.
  - `loadValid` is ignored.
- LOAD:
  - A byte is accepted when `loadValid` && `loadReady`.
  - Bytes shift into the assembly register MSB-first; byte index increments.
  - The byte completing a word writes {assembly, loadByte} to mem[write address], increments write address and `loadCount`, and clears the byte index.
- Last byte in LOAD:
  - Accepted `loadLast` byte that completes a word -> write, then RELEASE.
  - Accepted `loadLast` with a partial word -> FLUSH.
- FLUSH:
  - Writes the partial word left-aligned, zero-padded in the low bytes.
  - Increments `loadCount`, then RELEASE.
- RELEASE: one cycle, then RUN. CPU therefore sees at least one reset cycle after any load.
- Overflow:
  - A word completing when `loadCount` == 2**PC_WIDTH is not written; `loadOverflow` is set.
  - Write address does not wrap; the load continues to consume bytes until `loadLast`.
- `loadStart` during LOAD restarts the load: counters cleared, partial word discarded.
- `isReset` mid-load discards the partial word; completed words remain.
- Simultaneous `loadStart` and `isReset`: reset wins.
- No read/write collision: writes occur only in LOAD/FLUSH, reads only in RUN.

Optional Feature:
- PMEM_CHECKSUM_EN defined:
  - Adds output `loadChecksum` [7:0], the modulo-256 sum of all accepted bytes (including dropped overflow bytes).
  - Cleared by reset and by `loadStart`; held after the load ends.
- Undefined: port and adder absent; all other behaviour identical.

Test Plan:
- Load 0x12,0x34,0xAB,0xCD(last) -> mem[0]=0x1234, mem[1]=0xABCD, `loadCount`=2; `cpuReset`=1 through RELEASE; then `pc`=1 -> `instruction`=0xABCD one cycle later.
- Load 0x12,0x34,0x56(last) -> FLUSH writes mem[1]=0x5600, `loadCount`=2, `loadOverflow`=0.
- Load 257 words -> `loadCount`=256, `loadOverflow`=1, mem[255]=word 255, mem[0] not overwritten.
- `loadValid` toggled with gaps; `loadValid`=1 while in RUN -> `loadReady`=0 and memory unchanged; gapped bytes assemble identically.
- Reset mid-load after 3 bytes (word 0 complete) -> next cycle `cpuReset`=1, state RELEASE, then RUN; mem[0] retained; partial byte lost.
- With PMEM_CHECKSUM_EN defined: load 0xFF,0x02(last) -> `loadChecksum`=0x01.
